// File: rtl/bbox_pkg.sv
// Shared definitions for the bounding-box/highlight stage.
//   WIDTH_BITS / HEIGHT_BITS : default raster counter widths
//   LABEL_WIDTH              : width of region labels used elsewhere in the stage
//   bbox_ctrl_state_t        : frame sequencer state encoding (exposed for debug)
//   bbox_x_t / bbox_y_t / bbox_pcnt_t : column, row and pixel-count types
package bbox_pkg;
  localparam int WIDTH_BITS  = 11;
  localparam int HEIGHT_BITS = 10;
  localparam int LABEL_WIDTH = 8;
  localparam int PCNT_BITS   = WIDTH_BITS + HEIGHT_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } bbox_ctrl_state_t;

  typedef logic [WIDTH_BITS-1:0]  bbox_x_t;
  typedef logic [HEIGHT_BITS-1:0] bbox_y_t;
  typedef logic [PCNT_BITS-1:0]   bbox_pcnt_t;
endpackage

// File: rtl/bbox_raster_cnt.sv
// Raster position counters for one frame.
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : return x and y to 0 (priority over inc)
//   inc           : advance one pixel; x wraps at cfg_w-1 and y advances
//   cfg_w, cfg_h  : latched frame size
//   x, y          : current column / row
//   last          : current position is the final pixel (cfg_w-1, cfg_h-1)
module bbox_raster_cnt #(
  parameter int WB = 11,
  parameter int HB = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  input  logic [WB-1:0] cfg_w,
  input  logic [HB-1:0] cfg_h,
  output logic [WB-1:0] x,
  output logic [HB-1:0] y,
  output logic          last
);
  localparam logic [WB-1:0] ONE_X = WB'(1);
  localparam logic [HB-1:0] ONE_Y = HB'(1);

  logic [WB-1:0] x_q, x_d;
  logic [HB-1:0] y_q, y_d;
  logic          x_end;

  assign x_end = (x_q == cfg_w - ONE_X);
  assign last  = x_end && (y_q == cfg_h - ONE_Y);
  assign x     = x_q;
  assign y     = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (inc) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_q + ONE_Y;
      end else begin
        x_d = x_q + ONE_X;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
endmodule

// File: rtl/bbox_frame_ctrl.sv
// Frame sequencer for the bounding-box/highlight stage.
// Accepts a start command with a frame size, gates the upstream motion/RGB
// stream, presents each accepted pixel to the stage one cycle later with its
// raster position, then waits for the stage to emit W*H pixels before
// pulsing frame_done.
//
// Handshake: a pixel moves when in_valid && in_ready on a rising clock edge.
// in_ready is decoded from the state register alone (high only in STREAM),
// so it never depends combinationally on in_valid.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   start, abort             : frame start request, synchronous abort
//   cfg_width, cfg_height    : frame size, sampled on an accepted start
//   in_valid/in_ready/in_motion/in_rgb : upstream pixel stream
//   bb_enable, bb_motion_pixel, bb_rgb_pixel, bb_last_in_frame, bb_x, bb_y
//                            : registered pixel presentation to the stage
//   bb_pixel_valid           : stage output pixel strobe
//   busy, frame_done, cfg_err, timeout_err : status
//   state                    : current sequencer state (debug)
//
// Build option: define BBOX_FRAME_CTRL_TIMEOUT_EN to add a stall watchdog of
// TIMEOUT_CYCLES cycles; otherwise timeout_err is constant 0.
module bbox_frame_ctrl #(
  parameter int WIDTH_BITS     = 11,
  parameter int HEIGHT_BITS    = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WIDTH_BITS-1:0]  cfg_width,
  input  logic [HEIGHT_BITS-1:0] cfg_height,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_motion,
  input  logic [31:0]            in_rgb,
  output logic                   bb_enable,
  output logic                   bb_motion_pixel,
  output logic [31:0]            bb_rgb_pixel,
  output logic                   bb_last_in_frame,
  output logic [WIDTH_BITS-1:0]  bb_x,
  output logic [HEIGHT_BITS-1:0] bb_y,
  input  logic                   bb_pixel_valid,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   cfg_err,
  output logic                   timeout_err,
  output bbox_pkg::bbox_ctrl_state_t state
);
  import bbox_pkg::*;

  localparam int PB = WIDTH_BITS + HEIGHT_BITS;

  bbox_ctrl_state_t       state_q, state_d;
  logic [WIDTH_BITS-1:0]  w_q, w_d;
  logic [HEIGHT_BITS-1:0] h_q, h_d;
  logic [PB-1:0]          out_cnt_q, out_cnt_d;
  logic [PB-1:0]          target;
  logic                   bb_enable_q, bb_enable_d;
  logic                   bb_motion_q, bb_motion_d;
  logic [31:0]            bb_rgb_q, bb_rgb_d;
  logic                   bb_last_q, bb_last_d;
  logic [WIDTH_BITS-1:0]  bb_x_q, bb_x_d;
  logic [HEIGHT_BITS-1:0] bb_y_q, bb_y_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   timeout_err_q, timeout_err_d;

  logic                   cnt_clear, cnt_inc, cnt_last;
  logic [WIDTH_BITS-1:0]  cnt_x;
  logic [HEIGHT_BITS-1:0] cnt_y;
  logic                   xfer, active;

`ifdef BBOX_FRAME_CTRL_TIMEOUT_EN
  localparam int SB = $clog2(TIMEOUT_CYCLES + 1);
  logic [SB-1:0] stall_q, stall_d;
`endif

  // Full-width product so W*H can never wrap.
  assign target   = PB'(w_q) * PB'(h_q);
  assign in_ready = (state_q == STREAM);
  assign xfer     = in_valid && in_ready;
  assign active   = (state_q == STREAM) || (state_q == DRAIN);

  bbox_raster_cnt #(.WB(WIDTH_BITS), .HB(HEIGHT_BITS)) u_raster (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .cfg_w (w_q),
    .cfg_h (h_q),
    .x     (cnt_x),
    .y     (cnt_y),
    .last  (cnt_last)
  );

  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    h_d           = h_q;
    out_cnt_d     = out_cnt_q;
    cnt_clear     = 1'b0;
    cnt_inc       = 1'b0;
    bb_enable_d   = 1'b0;
    bb_last_d     = 1'b0;
    bb_motion_d   = bb_motion_q;
    bb_rgb_d      = bb_rgb_q;
    bb_x_d        = bb_x_q;
    bb_y_d        = bb_y_q;
    cfg_err_d     = 1'b0;
    timeout_err_d = 1'b0;
`ifdef BBOX_FRAME_CTRL_TIMEOUT_EN
    stall_d       = '0;
`endif

    // Stage output strobes saturate at W*H; extras are ignored.
    if (active && bb_pixel_valid && (out_cnt_q != target)) begin
      out_cnt_d = out_cnt_q + PB'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((cfg_width != '0) && (cfg_height != '0)) begin
            w_d       = cfg_width;
            h_d       = cfg_height;
            out_cnt_d = '0;
            cnt_clear = 1'b1;
            state_d   = STREAM;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (xfer) begin
          bb_enable_d = 1'b1;
          bb_motion_d = in_motion;
          bb_rgb_d    = in_rgb;
          bb_x_d      = cnt_x;
          bb_y_d      = cnt_y;
          if (cnt_last) begin
            bb_last_d = 1'b1;
            cnt_clear = 1'b1;
            state_d   = DRAIN;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DRAIN: begin
        // out_cnt_d already includes a strobe arriving this cycle.
        if (out_cnt_d == target) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef BBOX_FRAME_CTRL_TIMEOUT_EN
    if (active && !xfer && !bb_pixel_valid) begin
      if (stall_q == SB'(TIMEOUT_CYCLES - 1)) begin
        timeout_err_d = 1'b1;
        cnt_clear     = 1'b1;
        cnt_inc       = 1'b0;
        out_cnt_d     = '0;
        state_d       = IDLE;
      end else begin
        stall_d = stall_q + SB'(1);
      end
    end
`endif

    // Abort wins over start, over a final transfer and over the watchdog.
    if (abort) begin
      state_d       = IDLE;
      cnt_clear     = 1'b1;
      cnt_inc       = 1'b0;
      out_cnt_d     = '0;
      bb_enable_d   = 1'b0;
      bb_last_d     = 1'b0;
      bb_motion_d   = 1'b0;
      bb_rgb_d      = '0;
      bb_x_d        = '0;
      bb_y_d        = '0;
      cfg_err_d     = 1'b0;
      timeout_err_d = 1'b0;
`ifdef BBOX_FRAME_CTRL_TIMEOUT_EN
      stall_d       = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      w_q           <= '0;
      h_q           <= '0;
      out_cnt_q     <= '0;
      bb_enable_q   <= 1'b0;
      bb_motion_q   <= 1'b0;
      bb_rgb_q      <= '0;
      bb_last_q     <= 1'b0;
      bb_x_q        <= '0;
      bb_y_q        <= '0;
      cfg_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef BBOX_FRAME_CTRL_TIMEOUT_EN
      stall_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      w_q           <= w_d;
      h_q           <= h_d;
      out_cnt_q     <= out_cnt_d;
      bb_enable_q   <= bb_enable_d;
      bb_motion_q   <= bb_motion_d;
      bb_rgb_q      <= bb_rgb_d;
      bb_last_q     <= bb_last_d;
      bb_x_q        <= bb_x_d;
      bb_y_q        <= bb_y_d;
      cfg_err_q     <= cfg_err_d;
      timeout_err_q <= timeout_err_d;
`ifdef BBOX_FRAME_CTRL_TIMEOUT_EN
      stall_q       <= stall_d;
`endif
    end
  end

  assign state            = state_q;
  assign busy             = (state_q != IDLE);
  assign frame_done       = (state_q == DONE);
  assign bb_enable        = bb_enable_q;
  assign bb_motion_pixel  = bb_motion_q;
  assign bb_rgb_pixel     = bb_rgb_q;
  assign bb_last_in_frame = bb_last_q;
  assign bb_x             = bb_x_q;
  assign bb_y             = bb_y_q;
  assign cfg_err          = cfg_err_q;
  assign timeout_err      = timeout_err_q;
endmodule
